// File: rtl/kf_pkg.sv
// Shared Kalman-filter fixed-point defaults and FSM state encodings,
// common to the serial KF stages (inv2_serial, kgain_mul2_serial).
package kf_pkg;

    localparam int KF_N    = 20;
    localparam int KF_FRAC = 10;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_MAC  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

endpackage

// File: rtl/kf_round_sat.sv
// Round-half-up, arithmetic shift by FRAC and saturate a wide signed
// accumulator back to an N-bit fixed-point word; sat flags clipping.
module kf_round_sat
    import kf_pkg::*;
#(
    parameter int N    = KF_N,
    parameter int FRAC = KF_FRAC,
    parameter int IN_W = 2 * N + 1
) (
    input  logic signed [IN_W-1:0] din,
    output logic signed [N-1:0]    dout,
    output logic                   sat
);

    // One guard bit above the input keeps the rounding bias from wrapping.
    localparam logic signed [IN_W:0] HALF = {{(IN_W + 1 - FRAC){1'b0}}, 1'b1, {(FRAC - 1){1'b0}}};
    localparam logic signed [IN_W:0] MAXV = {{(IN_W + 2 - N){1'b0}}, {(N - 1){1'b1}}};
    localparam logic signed [IN_W:0] MINV = {{(IN_W + 2 - N){1'b1}}, {(N - 1){1'b0}}};

    function automatic logic [N:0] round_sat(input logic signed [IN_W-1:0] x);
        logic signed [IN_W:0] biased;
        logic signed [IN_W:0] shifted;
        biased  = {x[IN_W-1], x} + HALF;
        shifted = biased >>> FRAC;
        if (shifted > MAXV)
            return {1'b1, MAXV[N-1:0]};
        else if (shifted < MINV)
            return {1'b1, MINV[N-1:0]};
        else
            return {1'b0, shifted[N-1:0]};
    endfunction

    assign {sat, dout} = round_sat(din);

endmodule

// File: rtl/kgain_mul2_serial.sv
// Kalman gain K = M * Sinv for 2x2 fixed-point matrices, computed serially
// with a single multiplier over eight MAC cycles.
module kgain_mul2_serial
    import kf_pkg::*;
#(
    parameter int N    = KF_N,
    parameter int FRAC = KF_FRAC
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                start,
    input  logic signed [N-1:0] m11,
    input  logic signed [N-1:0] m12,
    input  logic signed [N-1:0] m21,
    input  logic signed [N-1:0] m22,
    input  logic signed [N-1:0] ia,
    input  logic signed [N-1:0] ib,
    input  logic signed [N-1:0] ic,
    input  logic signed [N-1:0] id,
    output logic                busy,
    output logic                done,
    output logic signed [N-1:0] k11,
    output logic signed [N-1:0] k12,
    output logic signed [N-1:0] k21,
    output logic signed [N-1:0] k22,
    output logic                ovf
);

    logic [1:0]            state;
    logic [2:0]            kcnt;
    logic signed [N-1:0]   lm11, lm12, lm21, lm22;
    logic signed [N-1:0]   lia, lib, lic, lid;
    logic signed [N-1:0]   op_m, op_s;
    logic signed [2*N-1:0] prod;
    logic signed [2*N:0]   prod_ext;
    logic signed [2*N:0]   acc;
    logic signed [2*N:0]   acc_sum;
    logic signed [N-1:0]   rs_out;
    logic                  rs_sat;

    assign busy = (state != ST_IDLE);
    assign done = (state == ST_DONE);

    // Step order walks K row by row: even steps pick the first term of a
    // dot product, odd steps the second.
    always_comb begin
        op_m = lm11;
        op_s = lia;
        case (kcnt)
            3'd0: begin op_m = lm11; op_s = lia; end
            3'd1: begin op_m = lm12; op_s = lic; end
            3'd2: begin op_m = lm11; op_s = lib; end
            3'd3: begin op_m = lm12; op_s = lid; end
            3'd4: begin op_m = lm21; op_s = lia; end
            3'd5: begin op_m = lm22; op_s = lic; end
            3'd6: begin op_m = lm21; op_s = lib; end
            3'd7: begin op_m = lm22; op_s = lid; end
            default: begin op_m = lm11; op_s = lia; end
        endcase
    end

    assign prod     = op_m * op_s;
    assign prod_ext = {prod[2*N-1], prod};
    assign acc_sum  = acc + prod_ext;

    kf_round_sat #(
        .N    (N),
        .FRAC (FRAC),
        .IN_W (2 * N + 1)
    ) u_round_sat (
        .din  (acc_sum),
        .dout (rs_out),
        .sat  (rs_sat)
    );

    // Operands are captured once at acceptance; the ports are free afterwards.
    always_ff @(posedge clk) begin
        if (state == ST_IDLE && start) begin
            lm11 <= m11;
            lm12 <= m12;
            lm21 <= m21;
            lm22 <= m22;
            lia  <= ia;
            lib  <= ib;
            lic  <= ic;
            lid  <= id;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
            kcnt  <= 3'd0;
            acc   <= '0;
            k11   <= '0;
            k12   <= '0;
            k21   <= '0;
            k22   <= '0;
            ovf   <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        ovf   <= 1'b0;
                        kcnt  <= 3'd0;
                        state <= ST_MAC;
                    end
                end
                ST_MAC: begin
                    acc  <= kcnt[0] ? acc_sum : prod_ext;
                    kcnt <= kcnt + 3'd1;
                    if (kcnt[0]) begin
                        ovf <= ovf | rs_sat;
                        case (kcnt[2:1])
                            2'd0:    k11 <= rs_out;
                            2'd1:    k12 <= rs_out;
                            2'd2:    k21 <= rs_out;
                            default: k22 <= rs_out;
                        endcase
                    end
                    if (kcnt == 3'd7)
                        state <= ST_DONE;
                end
                ST_DONE: state <= ST_IDLE;
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: doc/kgain_mul2_serial.md
KGAIN_MUL2_SERIAL -- requirements
Module: kgain_mul2_serial

Interface
REQ-001 SHALL have parameter N, default 20, meaning signed fixed-point word width.
REQ-002 SHALL have parameter FRAC, default 10, meaning fractional bits (scale S = 2^FRAC).
REQ-003 SHALL have port clk  input  1  single system clock; all state changes on its rising edge.
REQ-004 SHALL have port rst_n  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port start  input  1  one-cycle request to compute K = M * Sinv.
REQ-006 SHALL have ports m11, m12, m21, m22  input  N signed  M = P*H^T elements, row-major.
REQ-007 SHALL have ports ia, ib, ic, id  input  N signed  Sinv elements [ia ib; ic id], taken directly from the 2x2 inverse stage outputs IA, IB, IC, ID.
REQ-008 SHALL have port busy  output  1  high while a computation is in progress.
REQ-009 SHALL have port done  output  1  one-cycle pulse; K outputs are valid from this cycle on.
REQ-010 SHALL have ports k11, k12, k21, k22  output  N signed  registered gain elements.
REQ-011 SHALL have port ovf  output  1  high if any K element saturated in the last computation.

Function
REQ-012 SHALL implement the FSM states IDLE, MAC and DONE.
REQ-013 SHALL, in IDLE with start=1 at a rising edge (edge 0), latch all eight inputs, clear ovf, set busy, and go to MAC with step counter k=0.
REQ-014 SHALL use exactly one signed NxN multiplier, performing one product per MAC cycle, in order k=0..7: m11*ia, m12*ic, m11*ib, m12*id, m21*ia, m22*ic, m21*ib, m22*id.
REQ-015 SHALL keep a 2N+1-bit signed accumulator; even steps load the product and odd steps add it.
REQ-016 SHALL, on each odd step, add 2^(FRAC-1), arithmetic-shift right by FRAC, saturate to [-2^(N-1), 2^(N-1)-1], and register the result into k11, k12, k21 or k22 respectively.
REQ-017 SHALL set ovf if any saturation occurred during the computation.
REQ-018 SHALL, at edge 8 (the last MAC step), enter DONE and assert done=1 for exactly one cycle; at edge 9, return to IDLE and clear busy. Start-to-done latency is 8 cycles.
REQ-019 SHALL ignore start while in MAC or DONE; latched operands and the FSM are unaffected.
REQ-020 SHALL hold k11..k22 and ovf stable from DONE until the next accepted start, and shall not update them before their own step.
REQ-021 SHALL not depend on input ports after edge 0; inputs may change freely during MAC.

Reset
REQ-022 SHALL, on rst_n=0 at any time including mid-MAC, enter IDLE asynchronously with busy=0, done=0, ovf=0, k11..k22=0, k=0 and accumulator=0.
REQ-023 SHALL produce no done pulse for an operation aborted by reset; the first start after rst_n returns high SHALL be accepted normally.

Structure
REQ-024 SHALL place N, FRAC defaults and the FSM state encodings in the shared KF package, also used by inv2_serial.
REQ-025 SHALL implement the round/shift/saturate step as one sub-module, kf_round_sat, parameterised by N and FRAC and reusable by the other KF stages.
REQ-026 SHALL implement the operand-select mux, multiplier, accumulator, counter and FSM in the top module without further hierarchy.

Verification
REQ-027 SHALL test M=[1024 2048; 3072 4096] with Sinv=[512 0; 0 256] -> K=[512 512; 1536 1024], ovf=0, and done exactly 8 cycles after the start edge.
REQ-028 SHALL test rounding: m11=3, all other M elements 0, ia=512 -> k11=2 (1536+512>>10); m11=-1, ia=512 -> k11=0.
REQ-029 SHALL test saturation: m11=524287, ia=2048, all others 0 -> k11=524287, ovf=1; m11=-524288, ia=2048 -> k11=-524288, ovf=1.
REQ-030 SHALL test a second start pulse at cycle 3 of a computation -> it is ignored, exactly one done pulse occurs, and the results are those of the first operands.
REQ-031 SHALL test rst_n pulsed low at cycle 4 -> all outputs are 0 immediately, no done pulse occurs, and a following start yields the correct K with latency 8.
REQ-032 SHALL test a chained run with inv2_serial (a=2048, d=4096, b=c=0) feeding ia..id and M=[1024 0; 0 1024] -> K=[512 0; 0 256].
